regs: RTL
=========

# regs

Integer register file for the five-stage RV32I core: 32 × 32-bit general-purpose registers x0–x31. It answers the decode stage's two operand read requests combinationally and accepts one write per cycle from the write-back path. It also provides a handshaked debug port, so the testbench or a debug host can read or write any register without halting the pipeline.

## Interface
Parameters
- DBG_EN, default 1: 1 enables the debug port; 0 ties dbg_ack_o and dbg_rdata_o to 0 and ignores dbg_req_i.

Ports
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- reg1_raddr_i  in  5  operand-1 read address from decode.
- reg2_raddr_i  in  5  operand-2 read address from decode.
- reg1_rdata_o  out  32  operand-1 read data to decode.
- reg2_rdata_o  out  32  operand-2 read data to decode.
- reg_wen_i  in  1  core write enable from write-back.
- reg_waddr_i  in  5  core write address.
- reg_wdata_i  in  32  core write data.
- dbg_req_i  in  1  debug request; level, held until ack.
- dbg_we_i  in  1  1 = debug write, 0 = debug read.
- dbg_addr_i  in  5  debug register address.
- dbg_wdata_i  in  32  debug write data.
- dbg_ack_o  out  1  one-cycle completion pulse.
- dbg_rdata_o  out  32  debug read result; valid while dbg_ack_o = 1 and held until the next debug read completes.

## Operation

Register x0
- Always reads 0.
- Writes to x0 from either the core or the debug port are discarded.

Core read ports (combinational, independent)
- Address 0 returns 0.
- Else, if reg_wen_i = 1 and reg_waddr_i = read address, return reg_wdata_i (write-to-read bypass).
- Else return array[address].

Core write
- At the rising edge, if reg_wen_i = 1 and reg_waddr_i ≠ 0, then array[reg_waddr_i] ← reg_wdata_i.

Debug FSM, states IDLE, EXEC, ACK
- IDLE: dbg_req_i = 1 at the edge captures dbg_we_i, dbg_addr_i and dbg_wdata_i into holding registers, then → EXEC. Debug inputs are ignored in every other state.
- EXEC, write, reg_wen_i = 1: stay in EXEC. The core write has priority, so a debug write stalls one cycle per conflicting core write.
- EXEC, write, reg_wen_i = 0: at the edge, array[held addr] ← held data (discarded if addr = 0), then → ACK.
- EXEC, read: never stalls. At the edge, dbg_rdata_o ← read-port value of held addr, bypass included (a same-cycle core write to that address is returned), then → ACK.
- ACK: dbg_ack_o = 1, then → IDLE unconditionally.
- After an ack, dbg_req_i still high in IDLE is treated as a new request.

## Timing
- Reset (rst_n low, asynchronous):
  - All 32 registers = 0.
  - FSM = IDLE, dbg_ack_o = 0, dbg_rdata_o = 0.
  - reg1_rdata_o and reg2_rdata_o forced to 0 while rst_n is low, bypass included.
- Reset mid-operation: a captured but uncommitted debug write is discarded, and no ack is issued.
- Read ports: zero-cycle latency.
- Core write: visible through bypass in the same cycle; stored in the array from the next edge.
- Debug read: request sampled at the end of cycle N; dbg_ack_o high in cycle N+2. Fixed 2-cycle latency.
- Debug write: ack in cycle N+2+k, where k = number of EXEC cycles with reg_wen_i = 1.
- Debug write and core write never target the array in the same edge.
- Core read of an address being committed by a debug write: the old value before the edge, the new value after it. Debug writes are not bypassed.

## Test plan
- Reset, then read all 32 addresses on both ports → all 0. Write x5 = 0xDEADBEEF, then read next cycle → 0xDEADBEEF on both ports.
- reg_wen_i = 1, waddr = 7, wdata = 0x12345678, with reg1_raddr_i = 7 in the same cycle → reg1_rdata_o = 0x12345678 combinationally. Core write x0 = 0xFFFFFFFF → x0 reads 0.
- Debug read x5 (holds 0xDEADBEEF), request in cycle 0 → dbg_ack_o pulses in cycle 2 only, dbg_rdata_o = 0xDEADBEEF. Debug read with a same-cycle core write x5 = 0x1 during EXEC → dbg_rdata_o = 0x1.
- Debug write x9 = 0xA5A5A5A5 while reg_wen_i is held high for 3 cycles from EXEC entry → ack in cycle 5; x9 reads 0xA5A5A5A5 afterward. Debug write x0 → ack issued, x0 still 0.
- Debug write x3 captured, then rst_n pulsed low during EXEC → no ack, x3 = 0, FSM IDLE. A new request after reset completes normally.
- DBG_EN = 0: dbg_req_i held high for 10 cycles → dbg_ack_o stays 0 and no register changes.

Source files
------------

// File: rtl/regs_if.sv
// Debug access port of the integer register file: a level request held
// until a one-cycle acknowledge, carrying a read or a write of one register.
interface regs_if;
   logic        dbg_req_i;
   logic        dbg_we_i;
   logic [4:0]  dbg_addr_i;
   logic [31:0] dbg_wdata_i;
   logic        dbg_ack_o;
   logic [31:0] dbg_rdata_o;

   modport master (
      output dbg_req_i,
      output dbg_we_i,
      output dbg_addr_i,
      output dbg_wdata_i,
      input  dbg_ack_o,
      input  dbg_rdata_o
   );

   modport slave (
      input  dbg_req_i,
      input  dbg_we_i,
      input  dbg_addr_i,
      input  dbg_wdata_i,
      output dbg_ack_o,
      output dbg_rdata_o
   );
endinterface

// File: rtl/regs.sv
// RV32I integer register file: 32 x 32-bit registers with x0 hard-wired to
// zero, two combinational operand reads with write-to-read bypass, one
// write-back write per cycle, and a handshaked debug port that borrows the
// array only on cycles where write-back leaves it free.
module regs #(
   parameter bit DBG_EN = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [4:0]  reg1_raddr_i,
   input  logic [4:0]  reg2_raddr_i,
   output logic [31:0] reg1_rdata_o,
   output logic [31:0] reg2_rdata_o,
   input  logic        reg_wen_i,
   input  logic [4:0]  reg_waddr_i,
   input  logic [31:0] reg_wdata_i,
   regs_if.slave       dbg
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXEC,
      ST_ACK
   } dbg_state_e;

   logic [31:0] regs_q [32];
   logic [31:0] regs_d [32];

   dbg_state_e  state_q, state_d;
   logic        hold_we_q, hold_we_d;
   logic [4:0]  hold_addr_q, hold_addr_d;
   logic [31:0] hold_wdata_q, hold_wdata_d;
   logic [31:0] dbg_rdata_q, dbg_rdata_d;

   logic [31:0] rd1_val, rd2_val, rd_dbg_val;

   // Read-port value: x0 is zero, a same-cycle core write is forwarded.
   function automatic logic [31:0] port_val(
      input logic [4:0]  addr,
      input logic [31:0] stored,
      input logic        wen,
      input logic [4:0]  waddr,
      input logic [31:0] wdata
   );
      if (addr == 5'd0)
         return '0;
      else if (wen && (waddr == addr))
         return wdata;
      else
         return stored;
   endfunction

   // Operand and debug read values, all sharing the same bypass rule.
   always_comb begin
      rd1_val    = port_val(reg1_raddr_i, regs_q[reg1_raddr_i],
                            reg_wen_i, reg_waddr_i, reg_wdata_i);
      rd2_val    = port_val(reg2_raddr_i, regs_q[reg2_raddr_i],
                            reg_wen_i, reg_waddr_i, reg_wdata_i);
      rd_dbg_val = port_val(hold_addr_q, regs_q[hold_addr_q],
                            reg_wen_i, reg_waddr_i, reg_wdata_i);
   end

   // Bypass would otherwise leak write data while reset is held.
   assign reg1_rdata_o = rst_n ? rd1_val : '0;
   assign reg2_rdata_o = rst_n ? rd2_val : '0;

   assign dbg.dbg_ack_o   = DBG_EN && (state_q == ST_ACK);
   assign dbg.dbg_rdata_o = DBG_EN ? dbg_rdata_q : '0;

   // Debug sequencing plus the next array contents from both writers.
   always_comb begin
      state_d      = state_q;
      hold_we_d    = hold_we_q;
      hold_addr_d  = hold_addr_q;
      hold_wdata_d = hold_wdata_q;
      dbg_rdata_d  = dbg_rdata_q;
      regs_d       = regs_q;

      case (state_q)
         ST_IDLE: begin
            if (DBG_EN && dbg.dbg_req_i) begin
               hold_we_d    = dbg.dbg_we_i;
               hold_addr_d  = dbg.dbg_addr_i;
               hold_wdata_d = dbg.dbg_wdata_i;
               state_d      = ST_EXEC;
            end
         end
         ST_EXEC: begin
            if (hold_we_q) begin
               // Write-back owns the array; the debug write waits it out.
               if (!reg_wen_i) begin
                  if (hold_addr_q != 5'd0)
                     regs_d[hold_addr_q] = hold_wdata_q;
                  state_d = ST_ACK;
               end
            end else begin
               dbg_rdata_d = rd_dbg_val;
               state_d     = ST_ACK;
            end
         end
         ST_ACK:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      // Never collides with the debug commit above, which requires !reg_wen_i.
      if (reg_wen_i && (reg_waddr_i != 5'd0))
         regs_d[reg_waddr_i] = reg_wdata_i;
   end

   // Array, debug holding registers and FSM state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < 32; i++)
            regs_q[i] <= '0;
         state_q      <= ST_IDLE;
         hold_we_q    <= 1'b0;
         hold_addr_q  <= '0;
         hold_wdata_q <= '0;
         dbg_rdata_q  <= '0;
      end else begin
         regs_q       <= regs_d;
         state_q      <= state_d;
         hold_we_q    <= hold_we_d;
         hold_addr_q  <= hold_addr_d;
         hold_wdata_q <= hold_wdata_d;
         dbg_rdata_q  <= dbg_rdata_d;
      end
   end

endmodule
